// File: rtl/uart_pkt_decoder.sv
// Framed packet decoder for a UART byte stream: HEAD, payload, optional XOR checksum, TAIL.
// Accepted payloads are published on cfg_data; rejections pulse pkt_err with a reason code.
module uart_pkt_decoder #(
    parameter int          PAYLOAD_BYTES = 6,
    parameter logic [7:0]  HEAD          = 8'hAA,
    parameter logic [7:0]  TAIL          = 8'h55,
    parameter bit          CHK_EN        = 1'b1,
    parameter int          TIMEOUT_CYC   = 100000
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_done,
    output logic [PAYLOAD_BYTES*8-1:0] cfg_data,
    output logic                       cfg_valid,
    output logic                       pkt_err,
    output logic [1:0]                 err_code,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam int CW = $clog2(PAYLOAD_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int PW = PAYLOAD_BYTES * 8;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PAYLOAD   = 2'd1;
    localparam logic [1:0] S_CHECK     = 2'd2;
    localparam logic [1:0] S_TAIL_WAIT = 2'd3;

    localparam logic [1:0] E_CHK  = 2'b01;
    localparam logic [1:0] E_TAIL = 2'b10;
    localparam logic [1:0] E_TMO  = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    xor_q, xor_d;
    logic [PW-1:0] shadow_q, shadow_d;
    logic [PW-1:0] cfg_q, cfg_d;
    logic          cfg_valid_q, cfg_valid_d;
    logic          pkt_err_q, pkt_err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          expire;

    // rx_done is a single-cycle strobe with no backpressure: every strobe is consumed in its own cycle.
    // Expiry fires on the cycle the idle counter would reach TIMEOUT_CYC; a coincident byte wins.
    assign expire = (state_q != S_IDLE) && !rx_done && (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        shadow_d    = shadow_q;
        cfg_d       = cfg_q;
        cfg_valid_d = 1'b0;
        pkt_err_d   = 1'b0;
        err_code_d  = err_code_q;
        tmo_d       = (state_q == S_IDLE || rx_done) ? '0 : tmo_q + TW'(1);

        if (rx_done) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == HEAD) begin
                        state_d = S_PAYLOAD;
                        cnt_d   = '0;
                        xor_d   = '0;
                    end
                end
                S_PAYLOAD: begin
                    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                        if (cnt_q == CW'(i)) shadow_d[8*i +: 8] = rx_data;
                    end
                    xor_d = xor_q ^ rx_data;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(PAYLOAD_BYTES - 1)) begin
                        state_d = CHK_EN ? S_CHECK : S_TAIL_WAIT;
                    end
                end
                S_CHECK: begin
                    if (rx_data == xor_q) begin
                        state_d = S_TAIL_WAIT;
                    end else begin
                        state_d    = S_IDLE;
                        pkt_err_d  = 1'b1;
                        err_code_d = E_CHK;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    if (rx_data == TAIL) begin
                        cfg_d       = shadow_q;
                        cfg_valid_d = 1'b1;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = E_TAIL;
                    end
                end
            endcase
        end else if (expire) begin
            state_d    = S_IDLE;
            pkt_err_d  = 1'b1;
            err_code_d = E_TMO;
            tmo_d      = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            xor_q       <= '0;
            shadow_q    <= '0;
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            pkt_err_q   <= 1'b0;
            err_code_q  <= 2'b00;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xor_q       <= xor_d;
            shadow_q    <= shadow_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            pkt_err_q   <= pkt_err_d;
            err_code_q  <= err_code_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cfg_data  = cfg_q;
    assign cfg_valid = cfg_valid_q;
    assign pkt_err   = pkt_err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_pkt_decoder.sv
// Lockstep bench for uart_pkt_decoder: two builds (checksum on/off) fed the same byte stream
// and compared every cycle against a packet-level reference model.
module tb_uart_pkt_decoder;

    localparam int         P    = 6;
    localparam int         T    = 20;
    localparam logic [7:0] HEAD = 8'hAA;
    localparam logic [7:0] TAIL = 8'h55;

    // clock / reset
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;

    logic [P*8-1:0] cfg_data_c, cfg_data_n;
    logic           cfg_valid_c, cfg_valid_n, pkt_err_c, pkt_err_n, busy_c, busy_n;
    logic [1:0]     err_code_c, err_code_n, dbg_state_c, dbg_state_n;

    uart_pkt_decoder #(.PAYLOAD_BYTES(P), .HEAD(HEAD), .TAIL(TAIL), .CHK_EN(1'b1), .TIMEOUT_CYC(T)) dut_c (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .cfg_data(cfg_data_c), .cfg_valid(cfg_valid_c), .pkt_err(pkt_err_c),
        .err_code(err_code_c), .busy(busy_c), .dbg_state(dbg_state_c));

    uart_pkt_decoder #(.PAYLOAD_BYTES(P), .HEAD(HEAD), .TAIL(TAIL), .CHK_EN(1'b0), .TIMEOUT_CYC(T)) dut_n (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .cfg_data(cfg_data_n), .cfg_valid(cfg_valid_n), .pkt_err(pkt_err_n),
        .err_code(err_code_n), .busy(busy_n), .dbg_state(dbg_state_n));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // reference model state, index 0 = checksum build, 1 = no-checksum build
    bit             in_pkt[2];
    int             len_m[2];
    logic [7:0]     buf_m[2][0:15];
    int             last_cyc[2];
    logic [P*8-1:0] exp_cfg[2];
    logic [1:0]     exp_code[2];
    bit             exp_valid[2];
    bit             exp_err[2];

    logic [P*8-1:0] exp_q[$];
    logic [7:0]     tx_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            in_pkt[k]    = 1'b0;
            len_m[k]     = 0;
            last_cyc[k]  = 0;
            exp_cfg[k]   = '0;
            exp_code[k]  = 2'b00;
            exp_valid[k] = 1'b0;
            exp_err[k]   = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_reject(input int k, input logic [1:0] code);
        exp_err[k]  = 1'b1;
        exp_code[k] = code;
        in_pkt[k]   = 1'b0;
    endtask

    // Packet-level view: collect bytes after HEAD; judge the packet when it is long enough.
    task automatic model_step(input int k, input bit chk);
        logic [7:0] x;
        int full_len;
        full_len = P + (chk ? 2 : 1);
        exp_valid[k] = 1'b0;
        exp_err[k]   = 1'b0;
        if (rx_done) begin
            last_cyc[k] = cyc;
            if (!in_pkt[k]) begin
                if (rx_data == HEAD) begin
                    in_pkt[k] = 1'b1;
                    len_m[k]  = 0;
                end
            end else begin
                buf_m[k][len_m[k]] = rx_data;
                len_m[k]++;
                if (chk && len_m[k] == P + 1) begin
                    x = 8'h00;
                    for (int i = 0; i < P; i++) x ^= buf_m[k][i];
                    if (rx_data != x) model_reject(k, 2'b01);
                end else if (len_m[k] == full_len) begin
                    if (rx_data == TAIL) begin
                        for (int i = 0; i < P; i++) exp_cfg[k][8*i +: 8] = buf_m[k][i];
                        exp_valid[k] = 1'b1;
                        in_pkt[k]    = 1'b0;
                        if (k == 0) exp_q.push_back(exp_cfg[k]);
                    end else begin
                        model_reject(k, 2'b10);
                    end
                end
            end
        end else if (in_pkt[k] && (cyc - last_cyc[k]) == T) begin
            model_reject(k, 2'b11);
        end
    endtask

    task automatic compare_all();
        check("c_cfg_valid", 64'(cfg_valid_c), 64'(exp_valid[0]));
        check("c_pkt_err",   64'(pkt_err_c),   64'(exp_err[0]));
        check("c_err_code",  64'(err_code_c),  64'(exp_code[0]));
        check("c_busy",      64'(busy_c),      64'(in_pkt[0]));
        check("c_cfg_data",  64'(cfg_data_c),  64'(exp_cfg[0]));
        check("n_cfg_valid", 64'(cfg_valid_n), 64'(exp_valid[1]));
        check("n_pkt_err",   64'(pkt_err_n),   64'(exp_err[1]));
        check("n_err_code",  64'(err_code_n),  64'(exp_code[1]));
        check("n_busy",      64'(busy_n),      64'(in_pkt[1]));
        check("n_cfg_data",  64'(cfg_data_n),  64'(exp_cfg[1]));
        if (cfg_valid_c) begin
            if (exp_q.size() == 0) check("sb_unexpected_valid", 64'(1), 64'(0));
            else check("sb_payload", 64'(cfg_data_c), 64'(exp_q.pop_front()));
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too
    task automatic cycle(input logic d, input logic [7:0] b);
        rx_done = d;
        rx_data = b;
        @(posedge sys_clk);
        cyc++;
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        #1;
        compare_all();
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    // gap_mode 0: back-to-back strobes; 1: random small gaps with rare boundary gaps
    task automatic send_tx(input int gap_mode);
        int r;
        while (tx_q.size() > 0) begin
            cycle(1'b1, tx_q.pop_front());
            if (gap_mode == 1) begin
                r = $urandom_range(0, 29);
                if (r == 0) idle(T - 1);
                else if (r == 1) idle(T);
                else idle($urandom_range(0, 2));
            end
        end
    endtask

    task automatic push_pkt(input logic [7:0] pl[P], input bit with_chk, input logic [7:0] chk_xor,
                            input logic [7:0] tail);
        tx_q.push_back(HEAD);
        for (int i = 0; i < P; i++) tx_q.push_back(pl[i]);
        if (with_chk) tx_q.push_back(chk_xor);
        tx_q.push_back(tail);
    endtask

    logic [7:0] pl[P];
    logic [7:0] x;
    int kind;

    initial begin
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        compare_all();
        sys_rst_n = 1'b1;

        // basic accept
        tx_q = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h55};
        send_tx(0);
        idle(2);
        check("accept_literal", 64'(cfg_data_c), 64'h665544332211);
        idle(T);

        // checksum error
        tx_q = '{8'hAA, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 8'h55};
        send_tx(0);
        idle(T + 1);

        // tail error, then a good packet
        tx_q = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h56};
        send_tx(0);
        tx_q = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h55};
        send_tx(0);
        idle(T + 1);

        // timeout after a partial packet
        tx_q = '{8'hAA, 8'h11, 8'h22, 8'h33};
        send_tx(0);
        idle(T + 3);
        check("timeout_code", 64'(err_code_c), 64'(2'b11));

        // strobe landing exactly on the expiry cycle continues the packet
        tx_q = '{8'hAA, 8'h11, 8'h22, 8'h33};
        send_tx(0);
        idle(T - 1);
        tx_q = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h55};
        send_tx(0);
        idle(2);
        check("expiry_byte_wins", 64'(cfg_data_c), 64'h665544332211);
        idle(T);

        // garbage before a packet, then HEAD-valued payload
        tx_q = '{8'h00, 8'hFF, 8'h55};
        send_tx(0);
        check("garbage_busy", 64'(busy_c), 64'(0));
        tx_q = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h55};
        send_tx(0);
        idle(2);
        check("head_payload", 64'(cfg_data_c), 64'hAAAAAAAAAAAA);
        idle(T);

        // reset mid-packet, then full packet
        tx_q = '{8'hAA, 8'h11, 8'h22};
        send_tx(0);
        do_reset();
        check("reset_cfg", 64'(cfg_data_c), 64'(0));
        tx_q = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h55};
        send_tx(0);
        idle(T + 1);

        // packet shaped for the no-checksum build
        tx_q = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h55};
        send_tx(0);
        idle(2);
        check("nochk_accept", 64'(cfg_data_n), 64'h665544332211);
        idle(T);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 6);
            x = 8'h00;
            for (int i = 0; i < P; i++) begin
                pl[i] = ($urandom_range(0, 7) == 0) ? HEAD : 8'($urandom_range(0, 255));
                x ^= pl[i];
            end
            case (kind)
                0, 1: push_pkt(pl, 1'b1, x, TAIL);
                2:    push_pkt(pl, 1'b1, x ^ 8'($urandom_range(1, 255)), TAIL);
                3:    push_pkt(pl, 1'b1, x, TAIL ^ 8'($urandom_range(1, 255)));
                4:    push_pkt(pl, 1'b0, 8'h00, TAIL);
                5: begin
                    for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom_range(0, 255)));
                end
                default: begin
                    tx_q.push_back(HEAD);
                    for (int i = 0; i < 2; i++) tx_q.push_back(pl[i]);
                end
            endcase
            send_tx(1);
            if ($urandom_range(0, 19) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(T - 1, T + 2));
        end
        idle(T + 2);

        check("sb_drain", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_pkt_decoder.md
UART_PKT_DECODER -- requirements
Module: uart_pkt_decoder

Interface
- REQ-001: Parameter PAYLOAD_BYTES, default 6: number of payload bytes per packet; legal range 1..32.
- REQ-002: Parameter HEAD, default 8'hAA: packet header byte.
- REQ-003: Parameter TAIL, default 8'h55: packet tail byte.
- REQ-004: Parameter CHK_EN, default 1: 1 = XOR checksum byte between payload and tail; 0 = no checksum byte.
- REQ-005: Parameter TIMEOUT_CYC, default 100000: maximum idle gap, in sys_clk cycles, between bytes inside a packet.
- REQ-006: sys_clk  in  1  system clock; all logic rising-edge.
- REQ-007: sys_rst_n  in  1  asynchronous active-low reset.
- REQ-008: rx_data  in  8  received UART byte; valid only when rx_done=1.
- REQ-009: rx_done  in  1  one-cycle byte strobe from the UART receiver.
- REQ-010: cfg_data  out  PAYLOAD_BYTES*8  last good payload; byte i occupies bits [8i+7:8i].
- REQ-011: cfg_valid  out  1  one-cycle pulse when cfg_data updates.
- REQ-012: pkt_err  out  1  one-cycle pulse on packet rejection.
- REQ-013: err_code  out  2  reason for the last rejection: 01 checksum, 10 tail, 11 timeout; held until the next rejection.
- REQ-014: busy  out  1  high whenever the state is not IDLE.

Function
- REQ-015: FSM states SHALL be IDLE, PAYLOAD, CHECK and TAIL_WAIT; all transitions are registered and occur only on rx_done, timeout or reset.
- REQ-016: IDLE: rx_done with rx_data==HEAD -> PAYLOAD, byte count=0, xor_acc=0; any other byte is ignored silently, with no error.
- REQ-017: PAYLOAD: each rx_done stores rx_data into shadow byte [count] and updates xor_acc ^= rx_data; on byte PAYLOAD_BYTES -> CHECK if CHK_EN=1, else TAIL_WAIT.
- REQ-018: A HEAD-valued byte received inside PAYLOAD SHALL be treated as data; there is no resynchronisation.
- REQ-019: CHECK: rx_done with rx_data==xor_acc -> TAIL_WAIT; mismatch -> pkt_err pulse, err_code=01, IDLE.
- REQ-020: TAIL_WAIT: rx_done with rx_data==TAIL -> shadow copied to cfg_data, cfg_valid pulse, IDLE; mismatch -> pkt_err pulse, err_code=10, IDLE.
- REQ-021: cfg_data and cfg_valid SHALL change on the sys_clk edge after the tail-byte rx_done cycle; latency is 1 cycle.
- REQ-022: cfg_data SHALL be unchanged on any rejected packet; shadow writes never reach cfg_data directly.
- REQ-023: Timeout counter: width $clog2(TIMEOUT_CYC+1); cleared on every rx_done and held at 0 in IDLE; increments otherwise.
- REQ-024: Timeout: when the counter reaches TIMEOUT_CYC outside IDLE -> pkt_err pulse, err_code=11, IDLE.
- REQ-025: If rx_done coincides with timeout expiry, the byte SHALL win: it is processed normally and the counter is cleared.
- REQ-026: rx_done in the same cycle as a pkt_err or cfg_valid pulse cannot occur mid-FSM; the next byte after return to IDLE SHALL be evaluated as a potential HEAD.
- REQ-027: Byte counter width SHALL be $clog2(PAYLOAD_BYTES+1), with no wrap-around inside PAYLOAD.

Reset
- REQ-028: sys_rst_n=0 SHALL asynchronously force state=IDLE, cfg_data=0, cfg_valid=0, pkt_err=0, err_code=00, busy=0, counters=0, xor_acc=0 and shadow=0.
- REQ-029: Reset asserted mid-packet SHALL discard the partial packet; after release, the first HEAD starts a new packet.

Verification
- REQ-030: Defaults; bytes AA 11 22 33 44 55 66 77 55 -> cfg_data=48'h665544332211, one cfg_valid pulse 1 cycle after the tail strobe, pkt_err never asserted.
- REQ-031: Bytes AA 08 00 00 00 00 00 09 55 -> pkt_err pulse, err_code=01, cfg_data unchanged, busy=0 after the checksum byte.
- REQ-032: Bytes AA 11 22 33 44 55 66 77 56 -> err_code=10, cfg_data unchanged; the following valid packet is then accepted.
- REQ-033: AA 11 22 33, then stall for TIMEOUT_CYC cycles -> pkt_err pulse with err_code=11 exactly TIMEOUT_CYC cycles after the last strobe; a strobe landing on the expiry cycle instead continues the packet.
- REQ-034: Garbage bytes 00 FF 55 sent before the AA packet -> ignored, busy=0, then normal accept; the HEAD-valued payload AA AA .. AA with checksum 00 is accepted as data.
- REQ-035: Reset pulse after AA 11 22 -> all outputs 0, busy=0; a subsequent full valid packet is accepted; CHK_EN=0 build: AA 11 22 33 44 55 66 55 -> accepted.
